// File: rtl/div32_seq.sv
// -----------------------------------------------------------------------------
// div32_seq -- sequential 32-bit restoring divider, signed or unsigned.
//
// Retires one quotient bit per cycle. Divide-by-zero and the signed overflow
// case (0x80000000 / 0xFFFFFFFF) skip the iteration and go straight to DONE.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for operands, in_ready=1
//   DIV     | 32 restoring iterations, one quotient bit per cycle
//   FIXUP   | apply signs to quotient and remainder
//   DONE    | result held on outputs until out_ready
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (dividend, divisor, is_signed)
//   out_valid/out_ready result handshake (quotient, remainder, flags)
//   div_by_zero         divisor was zero
//   ovf                 signed 0x80000000 / 0xFFFFFFFF
//   busy                high in any state other than IDLE
// -----------------------------------------------------------------------------
module div32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  // dq holds the dividend magnitude; quotient bits shift in from the LSB as
  // dividend bits shift out of the MSB, so after 32 steps it is the quotient.
  logic [31:0] dq_q, dq_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign shifted = {rem_q, dq_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign mag_a   = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
  assign mag_b   = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (divisor == 32'd0) begin
            dq_d    = 32'hFFFF_FFFF;
            rem_d   = dividend;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else if (is_signed && (dividend == 32'h8000_0000) &&
                       (divisor == 32'hFFFF_FFFF)) begin
            dq_d    = 32'h8000_0000;
            rem_d   = 32'd0;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dq_d    = mag_a;
            dvs_d   = mag_b;
            rem_d   = 32'd0;
            cnt_d   = 5'd31;
            neg_a_d = is_signed & dividend[31];
            neg_b_d = is_signed & divisor[31];
            state_d = S_DIV;
          end
        end
      end

      S_DIV: begin
        // diff[32] set means the trial subtraction borrowed: restore.
        if (!diff[32]) begin
          rem_d = diff[31:0];
          dq_d  = {dq_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          dq_d  = {dq_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_FIXUP: begin
        if (neg_a_q ^ neg_b_q) dq_d  = 32'd0 - dq_q;
        if (neg_a_q)           rem_d = 32'd0 - rem_q;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dq_q    <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 5'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign quotient    = dq_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_div32_seq.sv
// -----------------------------------------------------------------------------
// tb_div32_seq -- self-checking bench for div32_seq.
// Expected results come from plain SystemVerilog arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_div32_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        ovf;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div32_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: signed division in SV truncates toward zero and the remainder
  // takes the dividend's sign, which is exactly the required behaviour.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; ov = 1'b1; lat = 1;
    end else if (s) begin
      q = sa / sb; r = sa % sb; lat = 34;
    end else begin
      q = a / b; r = a % b; lat = 34;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer operands, return the edge count at which out_valid was first seen.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output int edges);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = $urandom_range(0, 1);
    edges = 1;
    while (!out_valid && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int stall);
    logic [31:0] q, r;
    logic dz, ov;
    int lat, edges;
    model(a, b, s, q, r, dz, ov, lat);
    start_and_wait(a, b, s, edges);
    check({tag, "_latency"}, edges, lat);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_quotient"}, quotient, q);
    check({tag, "_remainder"}, remainder, r);
    check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, dz});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ov});
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      tick();
      check({tag, "_stall_quotient"}, quotient, q);
      check({tag, "_stall_remainder"}, remainder, r);
      check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_stall_out_valid"}, {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_retire_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_retire_flags"}, {30'd0, div_by_zero, ovf}, 32'd0);
    check({tag, "_retire_hold_q"}, quotient, q);
    check({tag, "_retire_hold_r"}, remainder, r);
    check({tag, "_retire_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic s, dz, ov;
    int lat, edges, seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    is_signed = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_flags", {30'd0, div_by_zero, ovf}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    // Accept on the very first edge after reset release.
    run_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
    check("u100_7_q_const", quotient, 32'd14);
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    check("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
    check("s_m7_2_r_const", remainder, 32'hFFFF_FFFF);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("dz_1234", 32'd1234, 32'd0, 1'b0, 0);
    check("dz_1234_r_const", remainder, 32'd1234);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("u_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    check("u_ovf_ops_r_const", remainder, 32'h8000_0000);
    run_op("s_min_1", 32'h8000_0000, 32'd1, 1'b1, 0);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0);
    run_op("dz_signed", 32'h8000_0001, 32'd0, 1'b1, 0);

    // Backpressure, then back-to-back accept with in_valid held high.
    model(32'd1000, 32'd9, 1'b0, q, r, dz, ov, lat);
    start_and_wait(32'd1000, 32'd9, 1'b0, edges);
    check("bp_latency", edges, 34);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_quotient", quotient, q);
      check("bp_remainder", remainder, r);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    dividend  = 32'd50;
    divisor   = 32'd6;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b_retire_out_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_retire_busy", {31'd0, busy}, 32'd0);
    check("b2b_in_ready_after", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_accepted", {31'd0, busy}, 32'd1);
    edges = 1;
    while (!out_valid && edges < 100) begin
      tick();
      edges++;
    end
    check("b2b_latency", edges, 34);
    check("b2b_quotient", quotient, 32'd8);
    check("b2b_remainder", remainder, 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a divide.
    dividend = 32'd77777; divisor = 32'd13; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_quotient", quotient, 32'd0);
    check("mid_rst_remainder", remainder, 32'd0);
    check("mid_rst_flags", {30'd0, div_by_zero, ovf}, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", seen, 0);
    run_op("after_rst_9_3", 32'd9, 32'd3, 1'b0, 0);
    check("after_rst_q_const", quotient, 32'd3);

    // Randomized operations with random early out_ready and stalls.
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: b = 32'd0 - $urandom_range(1, 20);
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      out_ready = $urandom_range(0, 1);
      run_op("rand", a, b, s, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
